// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - Row, layer and stage-split bookkeeping for the pipelined Wallace multiplier
//
// Purpose: elaboration-time helpers shared by wallace_mult_pipe and
// wallace_csa_layer. They compute how many rows enter each CSA layer, how
// many layers the tree needs for a given operand width, and after which
// layers the middle pipeline registers sit.
// Ports: none (package).

package wallace_pkg;

  // Rows left after one reduction layer: each full group of three rows
  // becomes a sum/carry pair, a leftover pair goes through half adders,
  // and a single leftover row passes straight through.
  function automatic int csa_out_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // WIDTH shifted partial-product rows plus one Baugh-Wooley constant row.
  function automatic int pp_rows(input int width);
    return width + 1;
  endfunction

  // Row count at the input of tree layer 'layer' (layer == csa_layers gives 2).
  function automatic int csa_rows_at(input int width, input int layer);
    int n;
    n = pp_rows(width);
    for (int l = 0; l < layer; l++) begin
      n = csa_out_rows(n);
    end
    return n;
  endfunction

  // Number of layers needed to bring the partial products down to two rows.
  function automatic int csa_layers(input int width);
    int n;
    int cnt;
    n   = pp_rows(width);
    cnt = 0;
    while (n > 2) begin
      n   = csa_out_rows(n);
      cnt = cnt + 1;
    end
    return cnt;
  endfunction

  // First tree layer handled by middle stage k (k = stages-2 returns the
  // total layer count). Only meaningful when stages > 2.
  function automatic int stage_first_layer(input int width, input int stages, input int k);
    return (k * csa_layers(width)) / (stages - 2);
  endfunction

  // True when a pipeline register closes a middle stage right after 'layer'.
  // With stages == 2 there are no middle stages and the whole tree sits
  // combinationally in front of the final adder.
  function automatic bit reg_after_layer(input int width, input int stages, input int layer);
    bit r;
    r = 1'b0;
    for (int k = 1; k <= stages - 2; k++) begin
      if (layer + 1 == stage_first_layer(width, stages, k)) begin
        r = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wallace_csa_layer.sv
// rtl/wallace_csa_layer.sv - One combinational 3:2 / 2:2 reduction layer of the Wallace tree
//
// Purpose: reduces N_IN rows of W2 bits to csa_out_rows(N_IN) rows while
// preserving their sum modulo 2^W2. Full groups of three rows go through
// full adders, a leftover pair through half adders, a single row passes.
// Ports:
//   rows_i  in   N_IN rows of W2 bits
//   rows_o  out  csa_out_rows(N_IN) rows of W2 bits

module wallace_csa_layer
  import wallace_pkg::*;
#(
  parameter int W2   = 16,
  parameter int N_IN = 9
) (
  input  logic [N_IN-1:0][W2-1:0]               rows_i,
  output logic [csa_out_rows(N_IN)-1:0][W2-1:0] rows_o
);

  localparam int NG  = N_IN / 3;
  localparam int REM = N_IN % 3;

  // Carries move one column up; the carry out of the top column is dropped
  // because the product is only defined modulo 2^W2.
  for (genvar g = 0; g < NG; g++) begin : g_fa
    logic [W2-1:0] x, y, z;
    assign x = rows_i[3*g];
    assign y = rows_i[3*g+1];
    assign z = rows_i[3*g+2];
    assign rows_o[2*g]   = x ^ y ^ z;
    assign rows_o[2*g+1] = {(x[W2-2:0] & y[W2-2:0]) |
                            (x[W2-2:0] & z[W2-2:0]) |
                            (y[W2-2:0] & z[W2-2:0]), 1'b0};
  end

  if (REM == 2) begin : g_ha
    logic [W2-1:0] x, y;
    assign x = rows_i[3*NG];
    assign y = rows_i[3*NG+1];
    assign rows_o[2*NG]   = x ^ y;
    assign rows_o[2*NG+1] = {x[W2-2:0] & y[W2-2:0], 1'b0};
  end else if (REM == 1) begin : g_pass
    assign rows_o[2*NG] = rows_i[3*NG];
  end

endmodule

// File: rtl/wallace_mult_pipe.sv
// rtl/wallace_mult_pipe.sv - Pipelined signed/unsigned Wallace-tree multiplier with valid/ready
//
// Purpose: WIDTH x WIDTH -> 2*WIDTH multiplier. Stage 1 registers the
// partial products (Baugh-Wooley in signed mode), middle stages hold the
// CSA tree layers split evenly, the last stage registers the final add.
// A single global stall freezes every stage while the product is refused.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand beat valid
//   in_ready     out  beat accepted this cycle when in_valid is also high
//   a, b         in   WIDTH-bit operands
//   signed_mode  in   1 = two's-complement operands, sampled with a/b
//   out_valid    out  prod valid
//   out_ready    in   consumer takes prod
//   prod         out  2*WIDTH-bit product
//   out_signed   out  signed_mode of the beat carried with prod

module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 out_signed
);

  localparam int W2  = 2 * WIDTH;
  localparam int NPP = pp_rows(WIDTH);
  localparam int NL  = csa_layers(WIDTH);

  logic                     stall;
  logic [STAGES-1:0]        vld_q;
  logic [STAGES-1:0]        sgn_q;
  logic [NPP-1:0][W2-1:0]   pp_d, pp_q;
  logic [1:0][W2-1:0]       sum_rows;
  logic [W2-1:0]            prod_d, prod_q;

  assign stall      = out_valid && !out_ready;
  assign in_ready   = !stall;
  assign out_valid  = vld_q[STAGES-1];
  assign out_signed = sgn_q[STAGES-1];
  assign prod       = prod_q;

  // Baugh-Wooley: in signed mode the cross terms that involve exactly one
  // operand MSB are inverted, and the constant row adds 1 at bits WIDTH and
  // 2*WIDTH-1. The MSB*MSB term keeps its positive weight.
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][i+j] = (a[j] & b[i]) ^
                       (signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp_d[WIDTH][WIDTH]  = signed_mode;
    pp_d[WIDTH][W2-1]   = signed_mode;
  end

  // Tree layers; a layer's input is either the previous layer's
  // combinational output or the register that closed the previous stage.
  for (genvar l = 0; l < NL; l++) begin : g_layer
    localparam int NI = csa_rows_at(WIDTH, l);
    localparam int NO = csa_rows_at(WIDTH, l + 1);

    logic [NI-1:0][W2-1:0] in_rows;
    logic [NO-1:0][W2-1:0] out_rows;
    logic [NO-1:0][W2-1:0] stage_rows;

    if (l == 0) begin : g_src_pp
      assign in_rows = pp_q;
    end else begin : g_src_prev
      assign in_rows = g_layer[l-1].stage_rows;
    end

    wallace_csa_layer #(
      .W2   (W2),
      .N_IN (NI)
    ) u_layer (
      .rows_i (in_rows),
      .rows_o (out_rows)
    );

    if (reg_after_layer(WIDTH, STAGES, l)) begin : g_reg
      logic [NO-1:0][W2-1:0] rows_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rows_q <= '0;
        end else if (!stall) begin
          rows_q <= out_rows;
        end
      end
      assign stage_rows = rows_q;
    end else begin : g_comb
      assign stage_rows = out_rows;
    end
  end

  assign sum_rows = g_layer[NL-1].stage_rows;
  assign prod_d   = sum_rows[0] + sum_rows[1];

  // While not stalled in_ready is 1, so capturing in_valid here is exactly
  // the accept condition; bubbles travel as zero valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sgn_q  <= '0;
      pp_q   <= '0;
      prod_q <= '0;
    end else if (!stall) begin
      vld_q  <= {vld_q[STAGES-2:0], in_valid};
      sgn_q  <= {sgn_q[STAGES-2:0], signed_mode};
      pp_q   <= pp_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier; next generation of the team's 4-bit combinational Wallace multiplier.
- Adds:
  - configurable operand width
  - per-transaction signed/unsigned mode (Baugh-Wooley)
  - a fixed-latency register pipeline
  - valid/ready handshakes on input and output, with backpressure
- Sits between operand-producing datapath logic and any consumer that may stall.

Parameters:
- WIDTH, 8: operand width in bits; legal 4..32.
- STAGES, 3: pipeline register stages. Legal values 2..4. Stage boundaries are fixed:
  - stage 1 = partial-product generation
  - middle stages = CSA tree layers, split evenly
  - last stage = final carry-propagate add

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- prod  out  2*WIDTH  full-precision product.
- out_signed  out  1  signed_mode of the transaction carried alongside prod.

Behaviour:
- Reset (async assert, sync-released by the integrator):
  - all stage valid bits = 0
  - out_valid = 0, prod = 0, out_signed = 0
  - in_ready = 1 immediately after reset.
- Transfers:
  - A beat is accepted when in_valid && in_ready.
  - A product is consumed when out_valid && out_ready.
- Global stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall, which is combinational from out_ready and registered out_valid.
  - While stalled, every stage register (data and valid) holds; no beat is accepted; prod and out_signed stay stable.
- Latency: exactly STAGES cycles from acceptance to out_valid when there are no stalls.
- Throughput: 1 beat per cycle. Bubbles (in_valid = 0) propagate as valid = 0 and do not stall the pipe.
- Ordering: strictly in-order; no beat may be dropped or duplicated.
- Arithmetic:
  - Unsigned: prod = a*b exactly (2*WIDTH bits, no overflow possible).
  - Signed: prod = $signed(a)*$signed(b) as a 2*WIDTH two's-complement value.
  - Signed partial products use Baugh-Wooley:
    - invert the MSB-row and MSB-column cross terms
    - add constant 1 at bit WIDTH and at bit 2*WIDTH-1
    - discard the carry out of bit 2*WIDTH-1.
  - Corner case: signed -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2); this must be representable and correct.
- Mixed modes: signed_mode may change every beat. Each beat's mode travels with its data through every stage.
- Reduction: the CSA tree uses 3:2 and 2:2 compressors only, until two rows remain. The final adder is a plain ripple or behavioural add of those two rows.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops asynchronously. No partial product may appear after reset release.
- Simultaneous consume and accept while out_valid = 1 and out_ready = 1: the pipe advances, and the new beat enters the same cycle.
- Non-valid stage registers may hold stale data; prod is only meaningful when out_valid = 1.

Decomposition:
- Shared package (wallace_pkg):
  - localparam functions for CSA layer count per width
  - row count per layer
  - stage-split indices, computed from WIDTH and STAGES.
- Sub-module: wallace_csa_layer. It is a combinational, parametrised one-layer 3:2/2:2 reduction over a row array, instantiated per tree layer.
- Top level (wallace_mult_pipe) holds:
  - the partial-product generator
  - pipeline registers
  - valid/mode shift chain
  - stall logic
  - final adder.

Test Plan:
- Exhaustive WIDTH=4, unsigned, out_ready = 1: all 256 (a,b) pairs streamed back-to-back -> prod = a*b, each appearing exactly STAGES cycles after acceptance; error count 0.
- Signed corners, WIDTH=8: (0x80,0x80) -> 0x4000; (0x80,0x01) -> 0xFF80; (0xFF,0xFF) -> 0x0001; (0x7F,0x80) -> 0xC080. Each product's out_signed = 1.
- Mixed mode per beat, WIDTH=8: a=0xFF, b=0x02 with signed_mode 0 then 1 -> 0x01FE then 0xFFFE, in order.
- Backpressure, WIDTH=8, STAGES=3:
  - stream 10 beats; hold out_ready = 0 for 5 cycles mid-stream
  - -> in_ready = 0 during the hold, prod stable, all 10 results delivered in order with none lost or duplicated.
- Bubbles: in_valid toggled 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed by STAGES.
- Reset mid-operation: assert rst_n = 0 with 3 beats in flight -> out_valid = 0 immediately. After release, out_valid stays 0 until new beats arrive and STAGES cycles pass.
